// File: rtl/count_capture_unit_pkg.sv
// -----------------------------------------------------------------------------
// count_cap_pkg
//   Shared types and constants for count_capture_unit:
//     - cap_state_e : capture FSM states (PRIME / IDLE / HOLD)
//     - CNT_W_DEF   : default width of the upstream count bus
//     - WRAP_W_DEF  : default width of the wrap counter / cap_wraps
//     - is_wrap()   : wrap-around test on two consecutive count samples
// -----------------------------------------------------------------------------
package count_cap_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 4;

  // PRIME : first cycle out of reset, loads prev_cnt and ignores events
  // IDLE  : no snapshot held, an event edge captures
  // HOLD  : snapshot presented, waiting for cap_ack
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    IDLE  = 2'd1,
    HOLD  = 2'd2
  } cap_state_e;

  // A wrap is exactly all-ones followed by zero. Any other jump to zero
  // (e.g. the upstream counter being reset from 7) is not a wrap.
  // Arguments are zero-extended to 32 bits so one function serves any width.
  function automatic logic is_wrap(input logic [31:0] prev,
                                   input logic [31:0] cur,
                                   input int unsigned width);
    logic [31:0] all_ones;
    all_ones = (32'd1 << width) - 32'd1;
    return (prev == all_ones) && (cur == 32'd0);
  endfunction

endpackage

// File: rtl/count_capture_unit_if.sv
// -----------------------------------------------------------------------------
// count_capture_unit_if
//   Snapshot handshake between count_capture_unit (master) and the
//   register-read / display stage that consumes it (slave).
//     cap_value   : captured count value
//     cap_wraps   : wraps seen since the previous successful capture
//     cap_valid   : snapshot held, awaiting cap_ack
//     cap_overrun : sticky, an event was dropped while cap_valid was high
//     cap_ack     : consumer has taken the snapshot (only meaningful while
//                   cap_valid is high)
// -----------------------------------------------------------------------------
interface count_capture_unit_if
  import count_cap_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) ();

  logic [CNT_W-1:0]  cap_value;
  logic [WRAP_W-1:0] cap_wraps;
  logic              cap_valid;
  logic              cap_overrun;
  logic              cap_ack;

  modport master (
    output cap_value,
    output cap_wraps,
    output cap_valid,
    output cap_overrun,
    input  cap_ack
  );

  modport slave (
    input  cap_value,
    input  cap_wraps,
    input  cap_valid,
    input  cap_overrun,
    output cap_ack
  );

endinterface

// File: rtl/count_capture_unit_rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
//   Turns the event strobe into a one-cycle pulse on its rising edge.
//   Holding evt_i high yields a single pulse.
//
//   Configuration macro: CAP_EVT_SYNC_EN
//     defined   : evt_i first passes through a 2-flop synchroniser, so the
//                 edge pulse appears two cycles later than in the default build
//     undefined : evt_i is assumed synchronous to clk
//
// Ports
//   clk    in  clock, all flops on posedge
//   reset  in  synchronous active-high reset, clears every flop
//   evt_i  in  event strobe
//   edge_o out one-cycle rising-edge pulse (combinational from the flops)
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic evt_i,
  output logic edge_o
);

  logic evt_s;    // event as seen in the clk domain
  logic evt_d_q;  // evt_s delayed one cycle

`ifdef CAP_EVT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= evt_i;
      sync2_q <= sync1_q;
    end
  end

  assign evt_s = sync2_q;
`else
  assign evt_s = evt_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_d_q <= 1'b0;
    end else begin
      evt_d_q <= evt_s;
    end
  end

  assign edge_o = evt_s && !evt_d_q;

endmodule

// File: rtl/count_capture_unit.sv
// -----------------------------------------------------------------------------
// count_capture_unit
//   Consumer of the upstream 4-bit up-counter. Detects wrap-around (15->0),
//   counts wraps since the last capture (saturating), and on a rising edge of
//   evt_in snapshots the count and the wrap total. The snapshot is offered on
//   a valid/ack handshake; events arriving while a snapshot is unacknowledged
//   are dropped and flagged by the sticky cap_overrun.
//
//   Configuration macro: CAP_EVT_SYNC_EN (see rise_edge_det) adds a 2-flop
//   synchroniser on evt_in; capture latency grows from 1 to 3 clocks.
//
// Ports
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   count_in    in   CNT_W  count bus from the upstream counter
//   evt_in      in   event strobe, rising edge requests a capture
//   wrap_pulse  out  one-cycle pulse, the cycle after a wrap is seen
//   cap_if      master modport: cap_value, cap_wraps, cap_valid,
//               cap_overrun out; cap_ack in
// -----------------------------------------------------------------------------
module count_capture_unit
  import count_cap_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            count_in,
  input  logic                        evt_in,
  output logic                        wrap_pulse,
  count_capture_unit_if.master        cap_if
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  cap_state_e        state_q, state_d;

  logic [CNT_W-1:0]  prev_cnt_q;
  logic [WRAP_W-1:0] wrap_cnt_q,  wrap_cnt_d;
  logic [CNT_W-1:0]  cap_value_q, cap_value_d;
  logic [WRAP_W-1:0] cap_wraps_q, cap_wraps_d;
  logic              overrun_q,   overrun_d;
  logic              wrap_pulse_q;

  logic              evt_edge;
  logic              in_prime, in_idle, in_hold;
  logic              wrap;
  logic              capture;
  logic              ack_ok;
  logic              overrun_evt;

  // ---------------------------------------------------------------------------
  // Event edge detector (optionally synchronised)
  // ---------------------------------------------------------------------------
  rise_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .evt_i  (evt_in),
    .edge_o (evt_edge)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // not in the sensitivity list; it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIME;
    end else begin
      // NOTE: state is updated with <= so every flop samples the values from
      // before this edge; = here would create order-dependent simulation.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_prime = (state_q == PRIME);
    in_idle  = (state_q == IDLE);
    in_hold  = (state_q == HOLD);
  end

  // HOLD is exactly "snapshot held, awaiting ack".
  assign cap_if.cap_valid = in_hold;

  // ---------------------------------------------------------------------------
  // Handshake / event qualification
  // ---------------------------------------------------------------------------
  // Wrap detection is suppressed in PRIME: prev_cnt has not yet been loaded
  // from a real count sample.
  assign wrap        = !in_prime &&
                       is_wrap(32'(prev_cnt_q), 32'(count_in), CNT_W);

  // An edge captures from IDLE, or from HOLD when the held snapshot is being
  // acked on the same cycle (new capture wins over the ack).
  assign capture     = evt_edge && (in_idle || (in_hold && cap_if.cap_ack));

  // A plain ack: only while valid, and only if no new edge replaces it.
  assign ack_ok      = cap_if.cap_ack && in_hold && !evt_edge;

  // Edge that cannot be honoured: snapshot still unacknowledged.
  assign overrun_evt = evt_edge && in_hold && !cap_if.cap_ack;

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      PRIME:   state_d = IDLE;
      IDLE:    if (capture) state_d = HOLD;
      HOLD:    if (ack_ok)  state_d = IDLE;   // ack + edge stays in HOLD
      default: state_d = PRIME;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: wrap counter, snapshot, overrun
  // ---------------------------------------------------------------------------
  always_comb begin
    wrap_cnt_d  = wrap_cnt_q;
    cap_value_d = cap_value_q;
    cap_wraps_d = cap_wraps_q;
    overrun_d   = overrun_q;

    if (capture) begin
      cap_value_d = count_in;
      // Snapshot reports the total before this cycle's wrap; a wrap landing
      // on the capture cycle is the first one of the next interval.
      cap_wraps_d = wrap_cnt_q;
      wrap_cnt_d  = WRAP_W'(wrap);
      overrun_d   = 1'b0;
    end else begin
      if (wrap && (wrap_cnt_q != '1)) begin
        wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
      if (overrun_evt) begin
        overrun_d = 1'b1;
      end else if (ack_ok) begin
        overrun_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt_q   <= '0;
      wrap_cnt_q   <= '0;
      cap_value_q  <= '0;
      cap_wraps_q  <= '0;
      overrun_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      prev_cnt_q   <= count_in;
      wrap_cnt_q   <= wrap_cnt_d;
      cap_value_q  <= cap_value_d;
      cap_wraps_q  <= cap_wraps_d;
      overrun_q    <= overrun_d;
      wrap_pulse_q <= wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cap_if.cap_value   = cap_value_q;
  assign cap_if.cap_wraps   = cap_wraps_q;
  assign cap_if.cap_overrun = overrun_q;
  assign wrap_pulse         = wrap_pulse_q;

endmodule

// File: tb/tb_count_capture_unit.sv
// -----------------------------------------------------------------------------
// tb_count_capture_unit
//   Directed bench for count_capture_unit (default build, CAP_EVT_SYNC_EN
//   undefined). The bench plays the upstream counter itself, free-running
//   from 0 after reset. Every capture it requests pushes the hand-computed
//   snapshot into exp_q; a monitor pops and compares whenever the DUT
//   presents a new snapshot (valid rising, or valid held across an ack).
// -----------------------------------------------------------------------------
module tb_count_capture_unit;

  typedef struct packed {
    logic [3:0] value;
    logic [3:0] wraps;
  } snap_t;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       evt_in;
  logic       wrap_pulse;
  logic [3:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  snap_t exp_q[$];

  count_capture_unit_if cap_if ();

  count_capture_unit dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .evt_in     (evt_in),
    .wrap_pulse (wrap_pulse),
    .cap_if     (cap_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: the DUT samples count_in = cnt, evt_in = e, cap_ack = a
  // at the next posedge. Returns 1 time unit after that edge. The upstream
  // counter advances only while out of reset.
  task automatic cyc(input logic e, input logic a);
    evt_in         = e;
    cap_if.cap_ack = a;
    count_in       = cnt;
    @(posedge clk);
    #1;
    if (!reset) cnt = cnt + 4'd1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic expect_snap(input logic [3:0] v, input logic [3:0] w);
    snap_t s;
    s.value = v;
    s.wraps = w;
    exp_q.push_back(s);
  endtask

  // Scoreboard monitor: a new snapshot is on the bus when valid is high now
  // and either was low last cycle or was acked last cycle.
  task automatic monitor();
    logic  prev_valid = 1'b0;
    logic  prev_ack   = 1'b0;
    snap_t s;
    forever begin
      @(negedge clk);
      if (cap_if.cap_valid === 1'b1 && (!prev_valid || prev_ack)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL snap_unexpected: got value=%0d wraps=%0d, expected none",
                   cap_if.cap_value, cap_if.cap_wraps);
        end else begin
          s = exp_q.pop_front();
          check("snap_value", 32'(cap_if.cap_value), 32'(s.value));
          check("snap_wraps", 32'(cap_if.cap_wraps), 32'(s.wraps));
        end
      end
      prev_valid = cap_if.cap_valid;
      prev_ack   = cap_if.cap_ack;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({cap_if.cap_valid, cap_if.cap_overrun, wrap_pulse,
                cap_if.cap_value, cap_if.cap_wraps});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    evt_in         = 1'b0;
    cap_if.cap_ack = 1'b0;
    count_in       = 4'd0;
    cnt            = 4'd0;

    fork
      monitor();
    join_none

    // ---- 1. reset for 2 clocks, then idle counting ----
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    run_n(6);                               // counts 0 (PRIME) .. 5
    check("idle_outputs", all_outs(), 32'd0);

    // ---- 2. event at count 6, no wraps yet ----
    expect_snap(4'd6, 4'd0);
    cyc(1'b1, 1'b0);                        // count 6
    check("cap_valid_after_evt", 32'(cap_if.cap_valid), 32'd1);
    cyc(1'b0, 1'b1);                        // count 7, ack
    check("cap_valid_after_ack", 32'(cap_if.cap_valid), 32'd0);

    // first wrap: pulse the cycle after 15 -> 0 is sampled
    run_n(7);                               // counts 8 .. 14
    cyc(1'b0, 1'b0);                        // count 15
    check("wrap_pulse_before", 32'(wrap_pulse), 32'd0);
    cyc(1'b0, 1'b0);                        // count 0: wrap #1
    check("wrap_pulse_high", 32'(wrap_pulse), 32'd1);
    cyc(1'b0, 1'b0);                        // count 1
    check("wrap_pulse_one_cycle", 32'(wrap_pulse), 32'd0);

    // ---- 3. two more wraps (3 total), then event at count 9 ----
    run_n(39);                              // counts 2..15, 0..15, 0..8
    expect_snap(4'd9, 4'd3);
    cyc(1'b1, 1'b0);                        // count 9
    check("cap_valid_s3", 32'(cap_if.cap_valid), 32'd1);

    // ---- 4. overrun, then ack + edge together ----
    cyc(1'b0, 1'b0);                        // count 10
    cyc(1'b1, 1'b0);                        // count 11: edge, no ack
    check("overrun_set", 32'(cap_if.cap_overrun), 32'd1);
    check("overrun_value_kept", 32'(cap_if.cap_value), 32'd9);
    check("overrun_wraps_kept", 32'(cap_if.cap_wraps), 32'd3);
    check("overrun_valid_kept", 32'(cap_if.cap_valid), 32'd1);
    cyc(1'b0, 1'b0);                        // count 12
    expect_snap(4'd13, 4'd0);               // wrap_cnt restarted at capture 9
    cyc(1'b1, 1'b1);                        // count 13: ack + edge
    check("ack_edge_valid", 32'(cap_if.cap_valid), 32'd1);
    check("ack_edge_overrun", 32'(cap_if.cap_overrun), 32'd0);
    cyc(1'b0, 1'b1);                        // count 14: plain ack
    check("ack_clears_valid", 32'(cap_if.cap_valid), 32'd0);

    // ---- 5. 20 wraps, capture on the wrap cycle, then restart ----
    run_n(320);                             // starts and ends at count 15
    cyc(1'b0, 1'b0);                        // count 15
    expect_snap(4'd0, 4'd15);               // saturated, pre-update total
    cyc(1'b1, 1'b0);                        // count 0: wrap + edge
    check("wrap_on_capture", 32'(wrap_pulse), 32'd1);
    cyc(1'b0, 1'b1);                        // count 1, ack
    run_n(3);                               // counts 2 .. 4
    expect_snap(4'd5, 4'd1);                // the capture-cycle wrap counts
    cyc(1'b1, 1'b0);                        // count 5
    cyc(1'b0, 1'b1);                        // count 6, ack

    // upstream counter reset 7 -> 0 is not a wrap
    cyc(1'b0, 1'b0);                        // count 7
    cnt = 4'd0;
    cyc(1'b0, 1'b0);                        // count 0 after a jump
    check("jump_not_wrap", 32'(wrap_pulse), 32'd0);

    // ---- 6. reset while a snapshot is held ----
    expect_snap(4'd1, 4'd0);
    cyc(1'b1, 1'b0);                        // count 1: capture
    reset = 1'b1;
    cyc(1'b0, 1'b1);                        // reset wins over the ack
    check("reset_mid_hold", all_outs(), 32'd0);
    reset = 1'b0;
    cnt   = 4'd0;
    cyc(1'b1, 1'b0);                        // PRIME: event ignored
    check("prime_evt_ignored", 32'(cap_if.cap_valid), 32'd0);
    cyc(1'b1, 1'b0);                        // still high: no new edge
    check("held_evt_no_edge", 32'(cap_if.cap_valid), 32'd0);
    cyc(1'b0, 1'b0);                        // count 2
    expect_snap(4'd3, 4'd0);
    cyc(1'b1, 1'b0);                        // count 3
    check("capture_after_reset", 32'(cap_if.cap_valid), 32'd1);
    cyc(1'b0, 1'b1);                        // ack
    cyc(1'b0, 1'b0);

    check("all_snapshots_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
